// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit add/subtract split into STAGES slices of CHUNK = WIDTH/STAGES
//   bits. Each slice sits in its own pipeline stage, with a registered carry
//   between stages. The whole pipeline advances together under a
//   valid/ready handshake.
//
//   The operand of each stage is op_b XOR {WIDTH{sub}}, so a subtract is
//   op_a + ~op_b + 1. Slices that are not yet summed ride forward in
//   shrinking skew registers. Slices that are already summed ride forward in
//   growing deskew registers. The last stage register is the output
//   register, so a transaction presented in cycle n is valid in cycle
//   n+STAGES.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready = advance)
//   op_a, op_b              operands
//   carry_in                carry into bit 0 (ignored when sub=1)
//   sub                     0: a+b+carry_in, 1: a-b
//   out_valid/out_ready     result handshake
//   sum                     result modulo 2^WIDTH
//   carry_out               carry out of MSB (for sub: 1 = no borrow)
//   overflow                signed overflow
//   zero                    sum == 0

// One CHUNK-bit slice of the adder (purely combinational).
module pipelined_adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s    = full[CHUNK-1:0];
  assign cout = full[CHUNK];
endmodule

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  // vld_pipe[0] is the incoming valid. vld_pipe[k+1] is the valid of stage k.
  logic [STAGES:0]  vld_pipe;

  // Stalls are global: the pipeline either shifts completely or holds completely.
  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance;
  assign b_eff       = op_b ^ {WIDTH{sub}};
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n)       vld_pipe[STAGES:1] <= '0;
    else if (advance) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    logic [CHUNK-1:0]         a_s, b_s, s_s;
    logic                     c_in, c_out;
    // Low (k+1) slices of the sum for the transaction in this stage.
    logic [(k+1)*CHUNK-1:0]   s_all;

    if (k == 0) begin : g_src
      assign a_s   = op_a[CHUNK-1:0];
      assign b_s   = b_eff[CHUNK-1:0];
      // A subtract forces the +1 of the two's complement. carry_in is ignored.
      assign c_in  = sub | carry_in;
      assign s_all = s_s;
    end else begin : g_src
      assign a_s   = stg[k-1].g_fwd.a_r[CHUNK-1:0];
      assign b_s   = stg[k-1].g_fwd.b_r[CHUNK-1:0];
      assign c_in  = stg[k-1].g_fwd.c_r;
      assign s_all = {s_s, stg[k-1].g_fwd.s_r};
    end

    pipelined_adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (a_s),
      .b    (b_s),
      .cin  (c_in),
      .s    (s_s),
      .cout (c_out)
    );

    if (k < STAGES-1) begin : g_fwd
      localparam int UP = WIDTH - (k+1)*CHUNK;
      logic [UP-1:0]          a_up, b_up;
      logic [UP-1:0]          a_r, b_r;   // skew: operand slices still to add
      logic [(k+1)*CHUNK-1:0] s_r;        // deskew: finished sum slices
      logic                   c_r;

      if (k == 0) begin : g_up
        assign a_up = op_a[WIDTH-1:CHUNK];
        assign b_up = b_eff[WIDTH-1:CHUNK];
      end else begin : g_up
        assign a_up = stg[k-1].g_fwd.a_r[UP+CHUNK-1:CHUNK];
        assign b_up = stg[k-1].g_fwd.b_r[UP+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
          s_r <= '0;
          c_r <= 1'b0;
        end else if (advance) begin
          a_r <= a_up;
          b_r <= b_up;
          s_r <= s_all;
          c_r <= c_out;
        end
      end
    end else begin : g_out
      logic c_msb;

      // Carry into the MSB is recovered from the MSB sum bit of the top slice.
      assign c_msb = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s_s[CHUNK-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum       <= '0;
          carry_out <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
        end else if (advance) begin
          sum       <= s_all;
          carry_out <= c_out;
          overflow  <= c_msb ^ c_out;
          zero      <= (s_all == '0);
        end
      end
    end
  end
endmodule
